led_fade_driver: RTL and testbench
==================================

Name: led_fade_driver

Overview:
- Downstream stage for the 8-LED chaser pattern generator. It consumes the chaser's 8-bit pattern, which runs on the slow divided clock, and drives the board LEDs.
- Each LED fades toward its pattern bit through a per-channel brightness level and a shared PWM counter, all on the fast system clock. Turning on ramps up and turning off decays, instead of hard switching.
- Sits between the chaser output and the LED pins in the top level.

Parameters:
- PWM_BITS, 8, PWM and brightness resolution. Full scale is MAX = 2^PWM_BITS-1.
- STEP_DIV, 500000, system-clock cycles between brightness step ticks. Minimum 2.
- STEP, 16, brightness change per step tick. Range 1..MAX.

Ports:
- CLK  in  1  system clock; every register updates on the rising edge.
- RST  in  1  asynchronous, active-high reset.
- PAT_I  in  8  LED pattern from the chaser; asynchronous to CLK.
- EN  in  1  1 = fading active; 0 = levels frozen.
- LVL_SEL  in  3  channel selected for observation.
- LED_O  out  8  PWM-modulated LED drive, registered.
- LVL_O  out  PWM_BITS  current level L[LVL_SEL], combinational from registers.
- BUSY  out  1  1 while any channel is not at its target level.

Behaviour:
- Reset (async, RST=1):
  - L[0..7]=0, A[0..7]=0, pc=0, prescaler=0, both sync stages=0.
  - LED_O=0, BUSY=0, LVL_O=0.
  - Reset during a ramp discards the ramp. After release, fading restarts from 0.
- Input sync:
  - PAT_I passes through a 2-FF synchronizer, giving T[7:0].
  - Latency from a PAT_I change to T is 2 CLK edges.
- Prescaler:
  - EN=1: counts 0..STEP_DIV-1 and wraps. tick=1 for one cycle when count==STEP_DIV-1.
  - EN=0: the prescaler is held at 0 and no tick is generated.
- Level update on tick, per channel i, with saturating arithmetic in a PWM_BITS+1-bit intermediate:
  - T[i]=1: L[i] = min(L[i]+STEP, MAX).
  - T[i]=0: L[i] = max(L[i]-STEP, 0).
  - Where T[i] changes, the new T[i] is applied on the same tick edge.
- PWM counter:
  - pc increments every cycle and wraps MAX -> 0. It runs regardless of EN.
- Shadow levels:
  - A[i] is loaded with L[i] on the edge where pc==MAX, so the duty changes only at a period boundary. No glitching mid-period.
- LED output, registered one cycle:
  - A[i]==MAX: LED_O[i]=1 constantly.
  - A[i]==0: LED_O[i]=0 constantly.
  - Otherwise: LED_O[i]=(pc<A[i]).
  - Resulting duty is A[i]/2^PWM_BITS per period.
- BUSY: OR over i of (L[i] != (T[i] ? MAX : 0)). It is registered and updated every cycle.
- LVL_O = L[LVL_SEL]. This is the live level, not the shadow.
- Simultaneous events:
  - A tick and a pc wrap in the same cycle: A loads the pre-tick L; the new L appears in the next period.
  - A PAT_I toggle while at saturation leaves the level at saturation until the next tick.

Test Plan:
Bench uses STEP_DIV=4, STEP=64, PWM_BITS=8.
1. Reset then idle: RST pulse, PAT_I=0x00, EN=1 -> LED_O=0x00, BUSY=0, LVL_O=0 held for 1000 cycles.
2. Ramp up: PAT_I 0x00->0x01, LVL_SEL=0 -> BUSY=1 within 3 cycles. Successive ticks give LVL_O=64,128,192,255 (saturation from 256 clamps to 255). BUSY=0 after the 4th tick.
3. Duty check at L0=64: after the next pc wrap, LED_O[0] is high for exactly 64 of each 256 cycles. At L0=255, LED_O[0] is high for all 256 cycles.
4. Decay: from L0=255, PAT_I=0x00 -> LVL_O=191,127,63,0 on successive ticks. LED_O[0] reaches constant 0 after the next period boundary.
5. Freeze and reset mid-ramp:
   - PAT_I=0xFF, EN=0 after 2 ticks -> all levels stay at 128 for 100 cycles. EN=1 resumes at 192.
   - Async RST mid-ramp -> LED_O=0x00 without waiting for a clock edge; levels are 0 after release.

Source files
------------

// File: rtl/led_fade_driver.sv
// LED fade stage: synchronises the chaser pattern and ramps each LED's
// brightness toward its pattern bit, then drives the pins with a shared PWM counter.
module led_fade_driver #(
    parameter int unsigned PWM_BITS = 8,
    parameter int unsigned STEP_DIV = 500000,
    parameter int unsigned STEP     = 16
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic [7:0]          PAT_I,
    input  logic                EN,
    input  logic [2:0]          LVL_SEL,
    output logic [7:0]          LED_O,
    output logic [PWM_BITS-1:0] LVL_O,
    output logic                BUSY
);

    localparam int unsigned PS_W = $clog2(STEP_DIV);
    localparam logic [PWM_BITS-1:0] MAX     = '1;
    localparam logic [PS_W-1:0]     PS_LAST = PS_W'(STEP_DIV - 1);
    localparam logic [PWM_BITS:0]   STEP_W  = (PWM_BITS + 1)'(STEP);

    logic [7:0]          sync1;
    logic [7:0]          sync2;
    logic [PS_W-1:0]     ps;
    logic [PWM_BITS-1:0] pc;
    logic                tick;

    logic [PWM_BITS-1:0] lvl      [8];
    logic [PWM_BITS-1:0] shadow   [8];
    logic [PWM_BITS-1:0] lvl_nxt  [8];
    logic [PWM_BITS:0]   up_sum   [8];
    logic [PWM_BITS:0]   dn_diff  [8];
    logic [7:0]          tgt_miss;
    logic [7:0]          led_nxt;

    assign tick  = EN && (ps == PS_LAST);
    assign LVL_O = lvl[LVL_SEL];

    // The extra intermediate bit flags overflow on the way up and borrow on the way down.
    always_comb begin
        tgt_miss = '0;
        led_nxt  = '0;
        for (int unsigned i = 0; i < 8; i++) begin
            up_sum[i]  = {1'b0, lvl[i]} + STEP_W;
            dn_diff[i] = {1'b0, lvl[i]} - STEP_W;
            if (sync2[i])
                lvl_nxt[i] = up_sum[i][PWM_BITS] ? MAX : up_sum[i][PWM_BITS-1:0];
            else
                lvl_nxt[i] = dn_diff[i][PWM_BITS] ? '0 : dn_diff[i][PWM_BITS-1:0];
            tgt_miss[i] = (lvl[i] != (sync2[i] ? MAX : '0));
            led_nxt[i]  = (shadow[i] == MAX) || (pc < shadow[i]);
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            sync1 <= '0;
            sync2 <= '0;
            ps    <= '0;
            pc    <= '0;
            LED_O <= '0;
            BUSY  <= 1'b0;
            for (int unsigned i = 0; i < 8; i++) begin
                lvl[i]    <= '0;
                shadow[i] <= '0;
            end
        end else begin
            sync1 <= PAT_I;
            sync2 <= sync1;
            if (!EN || ps == PS_LAST)
                ps <= '0;
            else
                ps <= ps + 1'b1;
            pc    <= pc + 1'b1;
            LED_O <= led_nxt;
            BUSY  <= |tgt_miss;
            // Shadow takes the pre-tick level when a tick and a period wrap coincide.
            for (int unsigned i = 0; i < 8; i++) begin
                if (tick)
                    lvl[i] <= lvl_nxt[i];
                if (pc == MAX)
                    shadow[i] <= lvl[i];
            end
        end
    end

endmodule

// File: tb/tb_led_fade_driver.sv
// Directed bench for led_fade_driver with a fast step tick (STEP_DIV=4, STEP=64).
module tb_led_fade_driver;

    logic       CLK = 1'b0;
    logic       RST;
    logic [7:0] PAT_I;
    logic       EN;
    logic [2:0] LVL_SEL;
    logic [7:0] LED_O;
    logic [7:0] LVL_O;
    logic       BUSY;

    int checks = 0;
    int errors = 0;

    led_fade_driver #(
        .PWM_BITS(8),
        .STEP_DIV(4),
        .STEP(64)
    ) dut (
        .CLK(CLK),
        .RST(RST),
        .PAT_I(PAT_I),
        .EN(EN),
        .LVL_SEL(LVL_SEL),
        .LED_O(LED_O),
        .LVL_O(LVL_O),
        .BUSY(BUSY)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge CLK);
    endtask

    // Waits (bounded) for the observed level to move; a timeout shows up in the following check.
    task automatic wait_lvl_change(input int bound);
        logic [7:0] prev;
        prev = LVL_O;
        for (int i = 0; i < bound; i++) begin
            @(negedge CLK);
            if (LVL_O !== prev) break;
        end
    endtask

    task automatic count_led0(output int highs);
        highs = 0;
        for (int i = 0; i < 256; i++) begin
            @(negedge CLK);
            if (LED_O[0] === 1'b1) highs++;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int highs;
        int any_high;

        // 1. reset then idle
        RST = 1'b1; PAT_I = 8'h00; EN = 1'b1; LVL_SEL = 3'd0;
        #2;
        check("rst_led", LED_O, 0);
        check("rst_busy", BUSY, 0);
        check("rst_lvl", LVL_O, 0);
        cyc(2);
        RST = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge CLK);
            check("idle", {LED_O, BUSY, LVL_O}, 0);
        end

        // 2. ramp up, with a freeze at 64 for the duty check
        PAT_I = 8'h01;
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            if (BUSY === 1'b1) break;
        end
        check("busy_rise", BUSY, 1);
        wait_lvl_change(12);
        check("ramp_64", LVL_O, 64);
        EN = 1'b0;

        // 3. duty at 64 and at full scale
        cyc(512);
        count_led0(highs);
        check("duty_64", highs, 64);
        check("frozen_64", LVL_O, 64);
        check("busy_frozen", BUSY, 1);
        EN = 1'b1;
        wait_lvl_change(12);
        check("ramp_128", LVL_O, 128);
        wait_lvl_change(12);
        check("ramp_192", LVL_O, 192);
        wait_lvl_change(12);
        check("ramp_255", LVL_O, 255);
        cyc(1);
        check("busy_fall_up", BUSY, 0);
        cyc(512);
        count_led0(highs);
        check("duty_255", highs, 256);
        check("sat_hold", LVL_O, 255);

        // 4. decay
        PAT_I = 8'h00;
        wait_lvl_change(12);
        check("decay_191", LVL_O, 191);
        wait_lvl_change(12);
        check("decay_127", LVL_O, 127);
        wait_lvl_change(12);
        check("decay_63", LVL_O, 63);
        wait_lvl_change(12);
        check("decay_0", LVL_O, 0);
        cyc(1);
        check("busy_fall_dn", BUSY, 0);
        cyc(512);
        count_led0(highs);
        check("duty_0", highs, 0);
        check("led_all_off", LED_O, 0);

        // 5a. freeze after two ticks on all channels
        PAT_I = 8'hFF;
        wait_lvl_change(12);
        check("all_64", LVL_O, 64);
        wait_lvl_change(12);
        check("all_128", LVL_O, 128);
        EN = 1'b0;
        for (int c = 0; c < 100; c++) begin
            @(negedge CLK);
            LVL_SEL = 3'(c % 8);
            #1;
            check("freeze_128", LVL_O, 128);
        end
        @(negedge CLK);
        LVL_SEL = 3'd0;
        EN = 1'b1;
        wait_lvl_change(12);
        check("resume_192", LVL_O, 192);

        // 5b. async reset mid-ramp
        any_high = 0;
        for (int i = 0; i < 600; i++) begin
            @(negedge CLK);
            if (LED_O !== 8'h00) begin
                any_high = 1;
                break;
            end
        end
        check("led_active", any_high, 1);
        #2;
        RST = 1'b1;
        #1;
        check("async_led", LED_O, 0);
        check("async_busy", BUSY, 0);
        check("async_lvl", LVL_O, 0);
        for (int s = 0; s < 8; s++) begin
            LVL_SEL = 3'(s);
            #1;
            check("rst_lvl_ch", LVL_O, 0);
        end
        LVL_SEL = 3'd0;
        cyc(2);
        RST = 1'b0;
        #1;
        check("post_rst_lvl", LVL_O, 0);
        wait_lvl_change(12);
        check("restart_64", LVL_O, 64);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
